// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared constants and state encoding for the IFFT symbol scheduler
package ofdm_pkg;
  localparam int NFFT = 64;
  localparam int N_PRE = 4;
  localparam int MAX_OUTST = 2;
  localparam int DW = 16;
  localparam logic [DW-1:0] CFG_WORD = 16'h5C10;
  localparam int BW = $clog2(NFFT);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NFFT - 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [7:0] PRE_LAST = 8'(N_PRE - 1);
  localparam logic [7:0] NPRE8 = 8'(N_PRE);
  typedef enum logic [2:0] {S_CFG, S_IDLE, S_PRE, S_DAT, S_DRAIN} state_e;
endpackage

// File: rtl/ofdm_ifft_sched_if.sv
// ofdm_ifft_sched_if: 16-bit sample stream with tlast
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror
interface ofdm_ifft_sched_if;
  import ofdm_pkg::*;
  logic [DW-1:0] tdata;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/ifft_sym_counter.sv
// ifft_sym_counter: beat counter within a symbol plus saturating count of symbols in flight
// hs_i: input beat accepted; dec_i: a symbol left the core; outst_d_o: next-cycle outst
module ifft_sym_counter
  import ofdm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hs_i,
  input  logic          dec_i,
  output logic [BW-1:0] beat_o,
  output logic [OW-1:0] outst_o,
  output logic [OW-1:0] outst_d_o
);
  logic [BW-1:0] beat_q, beat_d;
  logic [OW-1:0] outst_q;
  logic inc;
  always_comb begin
    inc = hs_i && beat_q == LAST_BEAT;
    beat_d = inc ? '0 : hs_i ? beat_q + 1'b1 : beat_q;
    outst_d_o = (inc && !dec_i && outst_q != OUTST_MAX) ? outst_q + 1'b1 :
                (dec_i && !inc && outst_q != '0) ? outst_q - 1'b1 : outst_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_q <= '0;
      outst_q <= '0;
    end else begin
      beat_q <= beat_d;
      outst_q <= outst_d_o;
    end
  assign beat_o = beat_q;
  assign outst_o = outst_q;
endmodule

// File: rtl/ofdm_ifft_sched.sv
// ofdm_ifft_sched: config issue, preamble/data grant, TLAST framing and flow control for the TX IFFT
// pre_i/dat_i: source streams; ifft_o: core input; cfg_*: one-shot config; ifft_out_*: core output monitor
// busy_o/frame_done_o/err_len_o/sym_idx_o: frame status
module ofdm_ifft_sched
  import ofdm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start_i,
  input  logic [7:0]               n_data_sym_i,
  ofdm_ifft_sched_if.slave         pre_i,
  ofdm_ifft_sched_if.slave         dat_i,
  ofdm_ifft_sched_if.master        ifft_o,
  output logic [DW-1:0]            cfg_tdata_o,
  output logic                     cfg_tvalid_o,
  input  logic                     cfg_tready_i,
  input  logic                     ifft_out_vld_i,
  input  logic                     ifft_out_rdy_i,
  input  logic                     ifft_out_last_i,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     err_len_o,
  output logic [7:0]               sym_idx_o
);
  state_e state_q;
  logic [7:0] nsym_q, sym_idx_q;
  logic busy_q, frame_done_q, err_len_q;
  logic [BW-1:0] beat;
  logic [OW-1:0] outst, outst_d;
  logic g_pre, g_dat, gate, last_beat, src_last, hs, sym_end;
  // only a new symbol waits for core room; an accepted symbol streams to its end
  assign g_pre = state_q == S_PRE;
  assign g_dat = state_q == S_DAT;
  assign last_beat = beat == LAST_BEAT;
  assign gate = beat != '0 || outst < OUTST_MAX;
  assign src_last = g_dat ? dat_i.tlast : pre_i.tlast;
  assign ifft_o.tdata = g_dat ? dat_i.tdata : pre_i.tdata;
  assign ifft_o.tvalid = gate && (g_pre ? pre_i.tvalid : g_dat && dat_i.tvalid);
  assign ifft_o.tlast = (g_pre || g_dat) && last_beat;
  assign pre_i.tready = g_pre && ifft_o.tready && gate;
  assign dat_i.tready = g_dat && ifft_o.tready && gate;
  assign hs = ifft_o.tvalid && ifft_o.tready;
  assign sym_end = hs && last_beat;
  ifft_sym_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .hs_i     (hs),
    .dec_i    (ifft_out_vld_i && ifft_out_rdy_i && ifft_out_last_i),
    .beat_o   (beat),
    .outst_o  (outst),
    .outst_d_o(outst_d)
  );
  // data symbol index is taken modulo 256 so long frames compare correctly after sym_idx wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_CFG;
      nsym_q <= '0;
      sym_idx_q <= '0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (hs && src_last != last_beat) err_len_q <= 1'b1;
      if (sym_end) sym_idx_q <= sym_idx_q + 1'b1;
      case (state_q)
        S_CFG: if (cfg_tready_i) state_q <= S_IDLE;
        S_IDLE:
          if (frame_start_i) begin
            nsym_q <= n_data_sym_i;
            sym_idx_q <= '0;
            busy_q <= 1'b1;
            state_q <= S_PRE;
          end
        S_PRE: if (sym_end && sym_idx_q == PRE_LAST) state_q <= nsym_q == '0 ? S_DRAIN : S_DAT;
        S_DAT: if (sym_end && 8'(sym_idx_q - NPRE8) == 8'(nsym_q - 8'd1)) state_q <= S_DRAIN;
        S_DRAIN:
          if (outst_d == '0) begin
            frame_done_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= S_IDLE;
          end
        default: state_q <= S_CFG;
      endcase
    end
  assign cfg_tdata_o = CFG_WORD;
  assign cfg_tvalid_o = state_q == S_CFG;
  assign busy_o = busy_q;
  assign frame_done_o = frame_done_q;
  assign err_len_o = err_len_q;
  assign sym_idx_o = sym_idx_q;
endmodule
